// File: rtl/button_event_classifier.sv
// -----------------------------------------------------------------------------
// button_event_classifier
//
// Purpose:
//   Consumes the clean level from the button debouncer and turns it into
//   single-cycle edge pulses plus one gesture classification per press:
//   short press, long press or double press. With auto-repeat built in, a
//   held long press (or held second press) also emits periodic repeat pulses.
//   All timing is counted in raw clock cycles.
//
// Optional feature:
//   BTN_AUTOREPEAT_EN - when defined, HOLD counts cycles and emits
//   repeat_pulse every REPEAT_CYCLES cycles. When undefined, repeat_pulse is
//   tied to 0 and the HOLD counting logic is not built.
//
// Parameters:
//   LONG_CYCLES   - cycles after rise_pulse at which a held press is "long"
//   GAP_CYCLES    - cycles after fall_pulse at which a lone press is "short";
//                   a second rise seen before then forms a double press
//   REPEAT_CYCLES - auto-repeat period while held (feature only)
//   CNT_W         - gesture counter width
//
// Ports:
//   clk          in   system clock, rising edge
//   reset        in   asynchronous, active-high reset
//   debounced    in   clean button level, synchronous to clk
//   rise_pulse   out  one-cycle pulse per 0->1 transition of debounced
//   fall_pulse   out  one-cycle pulse per 1->0 transition of debounced
//   short_press  out  one-cycle pulse: lone press released before threshold
//   long_press   out  one-cycle pulse: first press held to the threshold
//   double_press out  one-cycle pulse: second press within the gap window
//   repeat_pulse out  auto-repeat pulse while held (0 without the feature)
//   busy         out  high whenever the gesture FSM is not idle
// -----------------------------------------------------------------------------
module button_event_classifier #(
    parameter int unsigned LONG_CYCLES   = 8,
    parameter int unsigned GAP_CYCLES    = 5,
    parameter int unsigned REPEAT_CYCLES = 4,
    parameter int unsigned CNT_W         = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic debounced,
    output logic rise_pulse,
    output logic fall_pulse,
    output logic short_press,
    output logic long_press,
    output logic double_press,
    output logic repeat_pulse,
    output logic busy
);

    typedef enum logic [2:0] {
        StIdle,
        StPress1,
        StGap,
        StPress2,
        StHold
    } state_e;

    // cnt is 1 in the cycle where the edge pulse is visible, so matching it
    // against N in a cycle and registering the event lands the event pulse
    // exactly N cycles after that edge pulse.
    localparam logic [CNT_W-1:0] LongCnt = CNT_W'(LONG_CYCLES);
    localparam logic [CNT_W-1:0] GapCnt  = CNT_W'(GAP_CYCLES);
    localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CntMax  = {CNT_W{1'b1}};

    localparam int unsigned MaxLg     = (LONG_CYCLES > GAP_CYCLES) ? LONG_CYCLES : GAP_CYCLES;
    localparam int unsigned MaxCycles = (MaxLg > REPEAT_CYCLES) ? MaxLg : REPEAT_CYCLES;

    // Elaboration-time parameter sanity checks.
    if (LONG_CYCLES < 2 || GAP_CYCLES < 2 || REPEAT_CYCLES < 2) begin : g_bad_cycles
        $error("button_event_classifier: cycle parameters must be >= 2");
    end
    if (CNT_W < 63 && (longint'(1) << CNT_W) <= longint'(MaxCycles)) begin : g_narrow_cnt
        $error("button_event_classifier: CNT_W too narrow for the cycle parameters");
    end

    // -------------------------------------------------------------------------
    // Edge detection
    // -------------------------------------------------------------------------
    logic d_q;
    logic rise;
    logic fall;

    // d_q resets low, so a button already held at reset release yields a rise.
    assign rise = debounced & ~d_q;
    assign fall = ~debounced & d_q;

    // -------------------------------------------------------------------------
    // State, counter and registered outputs
    // -------------------------------------------------------------------------
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cnt_inc;

    logic rise_pulse_q, rise_pulse_d;
    logic fall_pulse_q, fall_pulse_d;
    logic short_press_q, short_press_d;
    logic long_press_q, long_press_d;
    logic double_press_q, double_press_d;
    logic busy_q, busy_d;

    // Saturating increment: the counter never wraps.
    assign cnt_inc = (cnt_q == CntMax) ? cnt_q : cnt_q + CntOne;

    // State register (process 1 of 3).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            d_q            <= 1'b0;
            state_q        <= StIdle;
            cnt_q          <= '0;
            rise_pulse_q   <= 1'b0;
            fall_pulse_q   <= 1'b0;
            short_press_q  <= 1'b0;
            long_press_q   <= 1'b0;
            double_press_q <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            d_q            <= debounced;
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            rise_pulse_q   <= rise_pulse_d;
            fall_pulse_q   <= fall_pulse_d;
            short_press_q  <= short_press_d;
            long_press_q   <= long_press_d;
            double_press_q <= double_press_d;
            busy_q         <= busy_d;
        end
    end

    // Next-state and counter logic (process 2 of 3). Releases and second
    // presses are checked before the thresholds so they win ties.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            StIdle: begin
                if (rise) begin
                    state_d = StPress1;
                    cnt_d   = CntOne;
                end
            end
            StPress1: begin
                if (fall) begin
                    state_d = StGap;
                    cnt_d   = CntOne;
                end else if (cnt_q == LongCnt) begin
                    state_d = StHold;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            StGap: begin
                if (rise) begin
                    state_d = StPress2;
                    cnt_d   = CntOne;
                end else if (cnt_q == GapCnt) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            StPress2: begin
                if (fall) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else if (cnt_q == LongCnt) begin
                    state_d = StHold;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            StHold: begin
                if (fall) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else begin
`ifdef BTN_AUTOREPEAT_EN
                    // cnt runs 0..REPEAT_CYCLES-1 in HOLD, one repeat per lap.
                    if (cnt_q == CNT_W'(REPEAT_CYCLES - 1)) begin
                        cnt_d = '0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
`endif
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    // Output decode (process 3 of 3). At most one gesture event per cycle
    // because each is tied to a distinct state.
    always_comb begin
        rise_pulse_d   = rise;
        fall_pulse_d   = fall;
        short_press_d  = 1'b0;
        long_press_d   = 1'b0;
        double_press_d = 1'b0;
        busy_d         = (state_d != StIdle);
        case (state_q)
            StPress1: begin
                if (!fall && cnt_q == LongCnt) begin
                    long_press_d = 1'b1;
                end
            end
            StGap: begin
                if (!rise && cnt_q == GapCnt) begin
                    short_press_d = 1'b1;
                end
            end
            StPress2: begin
                // Release or held second press: either way it is a double.
                if (fall || cnt_q == LongCnt) begin
                    double_press_d = 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

`ifdef BTN_AUTOREPEAT_EN
    logic repeat_pulse_q, repeat_pulse_d;

    always_comb begin
        repeat_pulse_d = 1'b0;
        // A release in the same cycle suppresses the repeat.
        if (state_q == StHold && !fall && cnt_q == CNT_W'(REPEAT_CYCLES - 1)) begin
            repeat_pulse_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            repeat_pulse_q <= 1'b0;
        end else begin
            repeat_pulse_q <= repeat_pulse_d;
        end
    end

    assign repeat_pulse = repeat_pulse_q;
`else
    assign repeat_pulse = 1'b0;
`endif

    assign rise_pulse   = rise_pulse_q;
    assign fall_pulse   = fall_pulse_q;
    assign short_press  = short_press_q;
    assign long_press   = long_press_q;
    assign double_press = double_press_q;
    assign busy         = busy_q;

endmodule
